fft_master: RTL and testbench

FFT_MASTER -- requirements
Module: fft_master

---
 rtl/fft_master.sv | 138 +++++++++++++
 tb/tb_fft_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_master.sv
// Master side of the 8-point FFT slave link: buffers samples, streams them over a
// 15-cycle sel window and captures up to eight results. Option: FFT_MASTER_ACKCHK_EN.
module fft_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sel,
  output logic [31:0] m_data_out,
  input  logic        ack,
  input  logic [31:0] m_data_in,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  rptr_q;
  logic        full_q;
  logic        busy_q;
  logic        done_q;
  logic        sel_q;
  logic [31:0] mdo_q;
  logic [15:0] sample_q [8];
  logic [31:0] result_q [8];

  logic        active;
  logic        rx_en;
  logic [1:0]  wsel_d;

  assign active = (state_q == SEND) || (state_q == RECV);
  // full_q stops the 3-bit pointer from wrapping back onto result[0]
  assign rx_en  = active && ack && !full_q;
  assign wsel_d = cnt_q[1:0] + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      mdo_q   <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        sample_q[i[2:0]] <= '0;
        result_q[i[2:0]] <= '0;
      end
    end else begin
      if (rx_en) begin
        result_q[rptr_q] <= m_data_in;
        rptr_q           <= rptr_q + 3'd1;
        if (rptr_q == 3'd7) full_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (wr_en) sample_q[wr_addr] <= wr_data;
          if (start) begin
            state_q <= SEND;
            sel_q   <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            mdo_q   <= {sample_q[0], sample_q[1]};
          end
        end
        SEND: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            state_q <= RECV;
            mdo_q   <= '0;
          end else begin
            mdo_q <= {sample_q[{wsel_d, 1'b0}], sample_q[{wsel_d, 1'b1}]};
          end
        end
        RECV: begin
          if (cnt_q == 4'd14) begin
            state_q <= DONE;
            sel_q   <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FFT_MASTER_ACKCHK_EN
  logic [3:0] ackcnt_q;
  logic [3:0] ackcnt_d;
  logic       err_q;

  always_comb begin
    ackcnt_d = ackcnt_q;
    if (active && ack && (ackcnt_q != 4'hF)) ackcnt_d = ackcnt_q + 4'd1;
  end

  // ackcnt_d includes an ack landing on the final window edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ackcnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) ackcnt_q <= '0;
      else                            ackcnt_q <= ackcnt_d;
      if ((state_q == RECV) && (cnt_q == 4'd14) && (ackcnt_d != 4'd8)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign sel        = sel_q;
  assign m_data_out = mdo_q;
  assign rd_data    = result_q[rd_addr];

endmodule

// File: tb/tb_fft_master.sv
// Directed bench for fft_master with a behavioural 8-point FFT slave on sel/ack.
module tb_fft_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        busy, done, sel, err;
  logic [31:0] m_data_out;
  logic        ack;
  logic [31:0] m_data_in;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;

  fft_master dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .sel        (sel),
    .m_data_out (m_data_out),
    .ack        (ack),
    .m_data_in  (m_data_in),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave: captures four words, computes the DFT, acks results on window cycles 5..12
  int                 k = 0;
  logic signed [15:0] x [8];
  logic [31:0]        X [8];
  bit                 drop_ack  = 1'b0;
  bit                 extra_ack = 1'b0;

  function automatic logic [15:0] rnd(input real v);
    int r;
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    return r[15:0];
  endfunction

  task automatic dft();
    real re, im, ang;
    int  xi;
    for (int m = 0; m < 8; m++) begin
      re = 0.0;
      im = 0.0;
      for (int n = 0; n < 8; n++) begin
        xi  = x[n];
        ang = 2.0 * 3.14159265358979 * m * n / 8.0;
        re  = re + xi * $cos(ang);
        im  = im - xi * $sin(ang);
      end
      X[m] = {rnd(re), rnd(im)};
    end
  endtask

  always @(negedge clk) begin
    if (!sel) begin
      k         = 0;
      ack       = 1'b0;
      m_data_in = '0;
    end else begin
      if (k < 4) begin
        x[2*k]   = m_data_out[31:16];
        x[2*k+1] = m_data_out[15:0];
      end
      if (k == 4) dft();
      ack       = 1'b0;
      m_data_in = '0;
      if (k >= 5 && k <= 12 && !(drop_ack && k == 8)) begin
        ack       = 1'b1;
        m_data_in = X[k-5];
      end
      if (extra_ack && k == 13) begin
        ack       = 1'b1;
        m_data_in = 32'hDEADBEEF;
      end
      k = (k == 14) ? 0 : k + 1;
    end
  end

  logic [31:0] mdo_log  [24];
  logic        sel_log  [24];
  logic        busy_log [24];
  logic        done_log [24];

  task automatic write_sample(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Fixed-length run; log index c is window cycle cnt=c
  task automatic run_txn(input int abort_at, input bit poke);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      sel_log[c]  = sel;
      busy_log[c] = busy;
      done_log[c] = done;
      mdo_log[c]  = m_data_out;
      wr_en = 1'b0;
      start = 1'b0;
      if (poke && c == 0) begin
        wr_en   = 1'b1;
        wr_addr = 3'd6;
        wr_data = 16'h7777;
        start   = 1'b1;
      end
      if (poke && c == 9) start = 1'b1;
      if (c == abort_at)     rst = 1'b1;
      if (c == abort_at + 1) rst = 1'b0;
      @(negedge clk);
    end
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_window(input string tag, input int exp_sel, input int exp_done);
    int ns, nd;
    ns = 0;
    nd = 0;
    for (int c = 0; c < 24; c++) begin
      if (sel_log[c])  ns++;
      if (done_log[c]) nd++;
    end
    chk({tag, "_selcnt"}, ns, exp_sel);
    chk({tag, "_donecnt"}, nd, exp_done);
  endtask

  task automatic check_result(input string tag, input int idx, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = idx[2:0];
    #1;
    chk($sformatf("%s_res%0d", tag, idx), rd_data, exp);
  endtask

  logic exp_err;

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    rd_addr = '0;
`ifdef FFT_MASTER_ACKCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_sel", sel, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mdo", m_data_out, 32'h0);
    rst = 1'b0;
    check_result("rst", 0, 32'h0);
    check_result("rst", 7, 32'h0);

    // Packing: samples 1..8
    for (int i = 0; i < 8; i++) write_sample(i[2:0], 16'(i + 1));
    run_txn(-10, 1'b0);
    chk("pack_w0", mdo_log[0], 32'h00010002);
    chk("pack_w1", mdo_log[1], 32'h00030004);
    chk("pack_w2", mdo_log[2], 32'h00050006);
    chk("pack_w3", mdo_log[3], 32'h00070008);
    chk("pack_w4", mdo_log[4], 32'h0);
    chk("pack_busy0", busy_log[0], 1'b1);
    chk("pack_sel14", sel_log[14], 1'b1);
    chk("pack_sel15", sel_log[15], 1'b0);
    chk("pack_done15", done_log[15], 1'b1);
    chk("pack_busy15", busy_log[15], 1'b1);
    chk("pack_busy16", busy_log[16], 1'b0);
    check_window("pack", 15, 1);
    check_result("pack", 0, 32'h00240000);
    check_result("pack", 4, 32'hFFFC0000);

    // Impulse
    write_sample(3'd0, 16'h0010);
    for (int i = 1; i < 8; i++) write_sample(i[2:0], 16'h0000);
    run_txn(-10, 1'b0);
    check_window("imp", 15, 1);
    for (int i = 0; i < 8; i++) check_result("imp", i, 32'h00100000);
    chk("imp_err", err, 1'b0);

    // DC
    for (int i = 0; i < 8; i++) write_sample(i[2:0], 16'h0010);
    run_txn(-10, 1'b0);
    check_window("dc", 15, 1);
    check_result("dc", 0, 32'h00800000);
    for (int i = 1; i < 8; i++) check_result("dc", i, 32'h0);

    // wr_en/start while busy must be ignored
    run_txn(-10, 1'b1);
    check_window("poke", 15, 1);
    chk("poke_w3", mdo_log[3], 32'h00100010);
    chk("poke_idle", sel_log[20], 1'b0);
    check_result("poke", 0, 32'h00800000);
    check_result("poke", 3, 32'h0);

    // Ninth ack must not overwrite result[0]
    extra_ack = 1'b1;
    run_txn(-10, 1'b0);
    extra_ack = 1'b0;
    check_window("sat", 15, 1);
    check_result("sat", 0, 32'h00800000);
    check_result("sat", 1, 32'h0);
    chk("sat_err", err, exp_err);

    // Abort at cnt=7
    run_txn(7, 1'b0);
    chk("abort_sel8", sel_log[8], 1'b0);
    check_window("abort", 8, 0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_err", err, 1'b0);
    check_result("abort", 0, 32'h0);
    check_result("abort", 5, 32'h0);
    write_sample(3'd0, 16'h0010);
    run_txn(-10, 1'b0);
    check_window("postabort", 15, 1);
    for (int i = 0; i < 8; i++) check_result("postabort", i, 32'h00100000);

    // Dropped ack
    drop_ack = 1'b1;
    run_txn(-10, 1'b0);
    drop_ack = 1'b0;
    check_window("drop", 15, 1);
    chk("drop_err", err, exp_err);
    repeat (5) @(negedge clk);
    chk("drop_err_sticky", err, exp_err);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("drop_err_clr", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
